// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive truth-table sweep of an N-input gate against a selectable reference reduction.
module gate_sweep_checker #(
    parameter int N_INPUTS = 2,
    parameter int SETTLE   = 1,
    parameter int ERR_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                bad_op,
    output logic [ERR_W-1:0]    err_count,
    output logic                first_err_valid,
    output logic [N_INPUTS-1:0] first_err_vec
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    state_t        state, state_nx;
    logic [2:0]    op_q;
    logic [CW-1:0] cnt;
    logic          ref_bit, mismatch, last_vec, legal;

    assign legal    = op < 3'd6;
    assign mismatch = dut_out != ref_bit;
    assign last_vec = &dut_in;

    always_comb begin
        ref_bit = 1'b0;
        case (op_q)
            3'd0:    ref_bit = ~&dut_in;
            3'd1:    ref_bit = &dut_in;
            3'd2:    ref_bit = |dut_in;
            3'd3:    ref_bit = ~|dut_in;
            3'd4:    ref_bit = ^dut_in;
            3'd5:    ref_bit = ~^dut_in;
            default: ref_bit = 1'b0;
        endcase
    end

    // An illegal-op start spends one busy cycle in DONE before raising done.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = start ? (legal ? ST_SETTLE : ST_DONE) : ST_IDLE;
            ST_SETTLE: state_nx = cnt == '0 ? ST_SAMPLE : ST_SETTLE;
            ST_SAMPLE: state_nx = last_vec ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_nx = done ? ST_IDLE : ST_DONE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= '0;
            cnt             <= '0;
            dut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            bad_op          <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q            <= op;
                        cnt             <= RELOAD;
                        dut_in          <= '0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        bad_op          <= !legal;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= dut_in;
                    end
                    if (last_vec) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= !mismatch && err_count == '0;
                    end else begin
                        dut_in <= dut_in + 1'b1;
                        cnt    <= RELOAD;
                    end
                end
                ST_DONE: begin
                    if (done) begin
                        done <= 1'b0;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed sweeps on three checker configurations with a queued expected-result scoreboard.
module tb_gate_sweep_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic [2:0] op [3];
    int         mode [3];
    logic       bsy [3], dn [3], ps [3], bo [3], fv [3], dout [3];
    logic [1:0] din0, fvec0;
    logic [7:0] ec0;
    logic [2:0] din1, fvec1;
    logic [7:0] ec1;
    logic [2:0] din2, fvec2;
    logic [1:0] ec2;
    int checks = 0, failures = 0;

    typedef struct {
        int         lat;
        logic [15:0] ec, fvec, din;
        logic        fv, ps, bo;
    } exp_t;
    exp_t sbq [$];

    always #5 clk = ~clk;

    // Behavioural gate: modes 0..5 follow the op encoding, 6 is stuck-at-0.
    function automatic logic gate(input int m, input logic [15:0] v, input int n);
        logic [15:0] mask, x;
        logic a, o, p;
        mask = 16'((32'd1 << n) - 1);
        x = v & mask;
        a = x == mask;
        o = x != 0;
        p = ^x;
        case (m)
            0: return !a;
            1: return a;
            2: return o;
            3: return !o;
            4: return p;
            5: return !p;
            default: return 1'b0;
        endcase
    endfunction

    assign dout[0] = gate(mode[0], 16'(din0), 2);
    assign dout[1] = gate(mode[1], 16'(din1), 3);
    assign dout[2] = gate(mode[2], 16'(din2), 3);

    gate_sweep_checker #(.N_INPUTS(2), .SETTLE(1), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op[0]), .dut_in(din0), .dut_out(dout[0]),
        .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .bad_op(bo[0]), .err_count(ec0),
        .first_err_valid(fv[0]), .first_err_vec(fvec0));
    gate_sweep_checker #(.N_INPUTS(3), .SETTLE(2), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op[1]), .dut_in(din1), .dut_out(dout[1]),
        .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .bad_op(bo[1]), .err_count(ec1),
        .first_err_valid(fv[1]), .first_err_vec(fvec1));
    gate_sweep_checker #(.N_INPUTS(3), .SETTLE(1), .ERR_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .op(op[2]), .dut_in(din2), .dut_out(dout[2]),
        .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .bad_op(bo[2]), .err_count(ec2),
        .first_err_valid(fv[2]), .first_err_vec(fvec2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic get(input int i, output logic [15:0] din, output logic [15:0] ec, output logic [15:0] fvec);
        case (i)
            0:       begin din = 16'(din0); ec = 16'(ec0); fvec = 16'(fvec0); end
            1:       begin din = 16'(din1); ec = 16'(ec1); fvec = 16'(fvec1); end
            default: begin din = 16'(din2); ec = 16'(ec2); fvec = 16'(fvec2); end
        endcase
    endtask

    task automatic chk_reset(input int i);
        logic [15:0] din, ec, fvec;
        get(i, din, ec, fvec);
        chk("rst_dut_in", din, 0);
        chk("rst_err_count", ec, 0);
        chk("rst_first_err_vec", fvec, 0);
        chk("rst_busy", bsy[i], 0);
        chk("rst_done", dn[i], 0);
        chk("rst_pass", ps[i], 0);
        chk("rst_bad_op", bo[i], 0);
        chk("rst_first_err_valid", fv[i], 0);
    endtask

    task automatic sweep(input int i, input logic [2:0] o, input int m, input int n, input int s,
                         input int ew, input bit steps, input bit disturb);
        exp_t e, g;
        int k, sat;
        logic [15:0] din, ec, fvec;
        sat = (1 << ew) - 1;
        e = '{lat: 0, ec: 16'd0, fvec: 16'd0, din: 16'd0, fv: 1'b0, ps: 1'b0, bo: 1'b0};
        mode[i] = m;
        if (o >= 3'd6) begin
            e.lat = 1;
            e.bo  = 1'b1;
        end else begin
            e.lat = (1 << n) * (s + 1);
            e.din = 16'((1 << n) - 1);
            for (int v = 0; v < (1 << n); v++)
                if (gate(m, 16'(v), n) != gate(int'(o), 16'(v), n)) begin
                    if (!e.fv) begin e.fv = 1'b1; e.fvec = 16'(v); end
                    if (int'(e.ec) < sat) e.ec++;
                end
            e.ps = e.ec == 0;
        end
        sbq.push_back(e);
        @(negedge clk);
        start[i] = 1'b1;
        op[i] = o;
        @(posedge clk);
        #1 start[i] = 1'b0;
        get(i, din, ec, fvec);
        chk("busy_after_start", bsy[i], 1);
        chk("dut_in_after_start", din, 0);
        k = 0;
        while (!dn[i] && k < 300) begin
            @(posedge clk);
            #1 k++;
            if (disturb && k == 2) begin start[i] = 1'b1; op[i] = 3'd4; end
            if (disturb && k == 3) start[i] = 1'b0;
            if (steps && !dn[i]) begin
                get(i, din, ec, fvec);
                chk("dut_in_step", din, 32'(k / (s + 1)));
            end
        end
        g = sbq.pop_front();
        get(i, din, ec, fvec);
        chk("done_latency", k, g.lat);
        chk("err_count", ec, g.ec);
        chk("first_err_vec", fvec, g.fvec);
        chk("first_err_valid", fv[i], g.fv);
        chk("pass", ps[i], g.ps);
        chk("bad_op", bo[i], g.bo);
        chk("final_dut_in", din, g.din);
        chk("busy_at_done", bsy[i], 0);
        @(posedge clk);
        #1 chk("done_one_cycle", dn[i], 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < 3; i++) begin op[i] = 3'd0; mode[i] = 0; end
        #12;
        for (int i = 0; i < 3; i++) chk_reset(i);
        @(negedge clk) rst_n = 1'b1;

        sweep(0, 3'd0, 0, 2, 1, 8, 1'b1, 1'b0);
        sweep(0, 3'd0, 6, 2, 1, 8, 1'b1, 1'b0);
        sweep(1, 3'd5, 4, 3, 2, 8, 1'b1, 1'b0);
        sweep(2, 3'd0, 1, 3, 1, 2, 1'b0, 1'b0);
        sweep(0, 3'd6, 2, 2, 1, 8, 1'b0, 1'b0);
        sweep(0, 3'd2, 2, 2, 1, 8, 1'b0, 1'b0);
        sweep(0, 3'd0, 0, 2, 1, 8, 1'b0, 1'b1);

        mode[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        op[0] = 3'd0;
        @(posedge clk);
        #1 start[0] = 1'b0;
        k = 0;
        while (din0 != 2'd2 && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        chk("reach_vector_2", 32'(din0), 2);
        #2 rst_n = 1'b0;
        #1 chk_reset(0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("no_done_in_reset", dn[0], 0);
        end
        @(negedge clk) rst_n = 1'b1;
        sweep(0, 3'd0, 0, 2, 1, 8, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
